// File: rtl/cu_pkg.sv
// Shared types and constants for the control-unit instruction sequencer.
package cu_pkg;

  // Sequencer phases
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    COMMIT = 3'd3,
    HALT   = 3'd4
  } cu_state_e;

  // Encoded reason for entering HALT
  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_ERR        = 3'd1,
    CAUSE_ECALL      = 3'd2,
    CAUSE_EBREAK     = 3'd3,
    CAUSE_PC_OOB     = 3'd4,
    CAUSE_MISALIGNED = 3'd5,
    CAUSE_TIMEOUT    = 3'd6
  } cu_halt_e;

  localparam int unsigned INSTR_BYTES = 4;
  // Number of PC low bits that must be zero for an aligned instruction
  localparam int unsigned ALIGN_W     = $clog2(INSTR_BYTES);

endpackage

// File: rtl/cu_watchdog.sv
// Per-state wait watchdog: counts cycles spent in a waiting state and flags
// the cycle in which the count reaches its all-ones limit.
module cu_watchdog #(
  parameter int unsigned WDT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [WDT_W-1:0] LIMIT = '1;
  localparam logic [WDT_W-1:0] LAST  = LIMIT - WDT_W'(1);

  logic [WDT_W-1:0] cnt;
  logic [WDT_W-1:0] base;

  // clear marks the first cycle of a new state, so counting restarts from zero
  assign base    = clear ? '0 : cnt;
  // This cycle is the one that brings the count up to LIMIT
  assign expired = count && (base == LAST);

  // Cycle counter, idle at zero whenever not counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= base + WDT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/cu_sequencer.sv
// Handshake-driven instruction-cycle sequencer with PC ownership and sticky
// halt-cause reporting. Optional macro CU_PERF_CNT_EN adds cycle/instret
// performance counters.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_LIMIT = 512,
  parameter int unsigned     WDT_W    = 8
) (
  input  logic            soc_clk,
  input  logic            reset,
  output logic            fetch_req,
  input  logic            fetch_ready,
  output logic            decode_start,
  input  logic            idu_ready,
  input  logic            idu_stall,
  input  logic            is_ecall,
  input  logic            is_ebreak,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic            err_in,
  input  logic [XLEN-1:0] pc_inc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc_out,
  output logic            retire,
  output logic [2:0]      state_out,
  output logic            halted,
  output logic [2:0]      halt_cause
`ifdef CU_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);

  localparam logic [XLEN:0] PC_LIMIT_EXT = (XLEN+1)'(PC_LIMIT);

  cu_state_e       state;
  logic [XLEN-1:0] pc;
  logic            entered;
  logic [XLEN:0]   seq_sum;
  logic [XLEN:0]   next_pc;
  logic            misaligned;
  logic            out_of_range;
  logic            wdt_count;
  logic            wdt_expired;

  assign pc_out    = pc;
  assign state_out = state;

  // Sequential sum keeps the carry so wrap-around is caught as out of range
  assign seq_sum = {1'b0, pc} + {1'b0, pc_inc};

  // Next-PC select: jump > taken branch > sequential; jumps clear bit 0
  always_comb begin
    next_pc = seq_sum;
    if (jump) begin
      next_pc = {1'b0, jump_target[XLEN-1:1], 1'b0};
    end else if (branch_taken) begin
      next_pc = {1'b0, branch_target};
    end
  end

  assign misaligned   = |next_pc[ALIGN_W-1:0];
  assign out_of_range = next_pc[XLEN] | (next_pc >= PC_LIMIT_EXT);

  assign wdt_count = (state == FETCH) || (state == DECODE) || (state == EXEC);

  cu_watchdog #(
    .WDT_W (WDT_W)
  ) u_wdt (
    .clk     (soc_clk),
    .rst     (reset),
    .clear   (entered),
    .count   (wdt_count),
    .expired (wdt_expired)
  );

  // Sequencer FSM; every output is registered alongside the state change
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      halted       <= 1'b0;
      halt_cause   <= CAUSE_NONE;
      fetch_req    <= 1'b1;
      decode_start <= 1'b0;
      alu_start    <= 1'b0;
      retire       <= 1'b0;
      entered      <= 1'b0;
    end else begin
      decode_start <= 1'b0;
      alu_start    <= 1'b0;
      retire       <= 1'b0;
      entered      <= 1'b0;
      if (state != HALT) begin
        if (err_in) begin
          state      <= HALT;
          halted     <= 1'b1;
          halt_cause <= CAUSE_ERR;
          fetch_req  <= 1'b0;
          entered    <= 1'b1;
        end else if (wdt_expired) begin
          state      <= HALT;
          halted     <= 1'b1;
          halt_cause <= CAUSE_TIMEOUT;
          fetch_req  <= 1'b0;
          entered    <= 1'b1;
        end else begin
          case (state)
            FETCH: begin
              if (fetch_ready) begin
                state        <= DECODE;
                decode_start <= 1'b1;
                fetch_req    <= 1'b0;
                entered      <= 1'b1;
              end
            end
            DECODE: begin
              if (idu_ready && !idu_stall) begin
                entered <= 1'b1;
                if (is_ebreak) begin
                  state      <= HALT;
                  halted     <= 1'b1;
                  halt_cause <= CAUSE_EBREAK;
                end else if (is_ecall) begin
                  state      <= HALT;
                  halted     <= 1'b1;
                  halt_cause <= CAUSE_ECALL;
                end else begin
                  state     <= EXEC;
                  alu_start <= 1'b1;
                end
              end
            end
            EXEC: begin
              if (alu_done) begin
                state   <= COMMIT;
                entered <= 1'b1;
              end
            end
            COMMIT: begin
              entered <= 1'b1;
              if (misaligned) begin
                state      <= HALT;
                halted     <= 1'b1;
                halt_cause <= CAUSE_MISALIGNED;
              end else if (out_of_range) begin
                state      <= HALT;
                halted     <= 1'b1;
                halt_cause <= CAUSE_PC_OOB;
              end else begin
                pc        <= next_pc[XLEN-1:0];
                retire    <= 1'b1;
                state     <= FETCH;
                fetch_req <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

`ifdef CU_PERF_CNT_EN
  // Performance counters, frozen once the sequencer has halted
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else if (state != HALT) begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (retire) begin
        instret_cnt <= instret_cnt + 64'd1;
      end
    end
  end
`else
  // No performance counters in this build
`endif

endmodule
